result_reader: RTL and testbench
================================

# result_reader

Streams the packed convolution results back out of the result memory after the convolution controller finishes its write phase. On a `start` pulse it reads NUM_WORDS consecutive words from BASE_ADR onward and unpacks each word into four result lanes. It then presents the lanes one per beat on a valid/ready output stream, LSB lane first. The block sits between the result memory's read port and the downstream consumer (host DMA or file-dump bench), and runs when the convolution controller's `done` pulses.

## Interface
- DATA_W, 32: result memory word width; must be a multiple of 4.
- LANE_W, DATA_W/4: width of one packed result.
- ADDR_W, 8: memory address width.
- BASE_ADR, 0: first result word address.
- NUM_WORDS, 43: words to read per run; legal range 1..2^ADDR_W.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start  in  1  one-cycle run request; sampled only in IDLE.
- mem_rd_en  out  1  read strobe to the result memory.
- mem_rd_adr  out  ADDR_W  read address (BASE_ADR + word index).
- mem_rd_data  in  DATA_W  read data, valid the cycle after `mem_rd_en`.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANE_W  current lane of the current word.
- out_last  out  1  high on the final beat of the run (lane 3 of the last word).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the run completes.

## Operation
- States: IDLE, RD, WAIT, SEND, DONE.
- IDLE: when `start`=1, go to RD, clear word_idx and lane.
- RD: `mem_rd_en`=1, `mem_rd_adr`=BASE_ADR+word_idx. Go to WAIT.
- WAIT: capture `mem_rd_data` into word_reg and go to SEND.
- SEND:
  - `out_valid`=1 and `out_data`=word_reg[lane*LANE_W +: LANE_W].
  - On `out_valid & out_ready`, lane increments.
  - When lane 3 is accepted: if word_idx==NUM_WORDS-1, go to DONE. Otherwise, word_idx increments, lane goes to 0, and the next state is RD (SEND when prefetch is enabled).
- DONE: `done`=1 for one cycle, then go to IDLE.
- Handshake: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable. `out_valid` never drops before the beat is accepted.
- Address arithmetic is modulo 2^ADDR_W and wraps silently.
- `start` outside IDLE is ignored, including in the DONE cycle.
- Reset, at any time including mid-run:
  - all outputs go to 0, state goes to IDLE, counters and registers clear;
  - an in-flight read is discarded.

## Timing
- Reset values: `mem_rd_en`=0, `mem_rd_adr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- Latency from `start` to first `out_valid` is 3 cycles: start is sampled at edge 0, RD runs in cycle 1, WAIT in cycle 2, SEND in cycle 3.
- Without prefetch, each word costs 2 bubble cycles (RD, WAIT) plus 4 beats. With `out_ready` held at 1, a run takes 6·NUM_WORDS + 2 cycles from start to `done`.
- `done` asserts the cycle after the last beat is accepted.
- All outputs are registered or decoded from the state register only; there is no combinational path from `out_ready` to `mem_rd_en`, except the prefetch issue described under Configuration.

## Configuration
- Macro: `RESULT_READER_PREFETCH_EN`.
- Defined:
  - In SEND, when lane 2 is accepted and word_idx<NUM_WORDS-1, `mem_rd_en`=1 with `mem_rd_adr`=BASE_ADR+word_idx+1 in that same cycle.
  - Data returning the next cycle goes into pf_reg (pf_full=1).
  - When lane 3 is accepted, word_reg loads from pf_reg; if that accept happens in the data-return cycle itself, word_reg loads directly from `mem_rd_data`.
  - SEND continues with lane 0, skipping RD/WAIT after the first word.
  - With `out_ready`=1, the stream is gapless, one beat per cycle, and a run takes 4·NUM_WORDS + 4 cycles.
- Undefined: behaviour is exactly the RD/WAIT/SEND sequence above, and pf_reg is not instantiated.

## Test plan
- Reset and basic run:
  - Stimulus: memory[0..42] = {word i = lanes i*4+3..i*4}, start pulse, `out_ready`=1.
  - Required response: 172 beats with values 0..171 in order; `out_last` only on value 171; `done` one cycle after; no-prefetch start-to-done = 260 cycles, prefetch = 176.
- Backpressure:
  - Stimulus: toggle `out_ready` pseudo-randomly, 50%.
  - Required response: identical value sequence; `out_data` stable while stalled; no beat dropped or duplicated.
- Prefetch corner:
  - Stimulus: hold `out_ready`=0 on lane 3 for 5 cycles, then accept.
  - Required response: the next word comes from pf_reg and the beat is correct. Also accept lane 3 in the data-return cycle and check the direct `mem_rd_data` load.
- Ignored start:
  - Stimulus: pulse `start` mid-run and in the DONE cycle.
  - Required response: no restart and beat count unchanged.
- Reset mid-run:
  - Stimulus: assert `rst`=0 during WAIT of word 10.
  - Required response: all outputs 0 immediately (asynchronous). After release, a new start yields a full run from word 0.
- NUM_WORDS=1, BASE_ADR=255, ADDR_W=8:
  - Stimulus: single-word run at the top of the address space.
  - Required response: exactly one read at 255, 4 beats, `out_last` on beat 4, no prefetch read issued.

Source files
------------

// File: rtl/result_reader_if.sv
// Bus bundle for result_reader: result-memory read port plus the lane output stream.
// Stream handshake: a beat transfers on a rising clk edge where out_valid and out_ready are both 1;
// while out_valid=1 and out_ready=0 the source holds out_data/out_last and keeps out_valid high.
interface result_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) ();
    localparam int LANE_W = DATA_W / 4;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_adr;
    logic [DATA_W-1:0] mem_rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [LANE_W-1:0] out_data;
    logic              out_last;

    modport master (
        output mem_rd_en,
        output mem_rd_adr,
        input  mem_rd_data,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_last
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_adr,
        output mem_rd_data,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_last
    );
endinterface

// File: rtl/result_reader.sv
// Reads NUM_WORDS packed result words from BASE_ADR and streams their four lanes, LSB lane first.
// Optional macro RESULT_READER_PREFETCH_EN fetches the next word during lane 2 for a gapless stream.
module result_reader #(
    parameter int DATA_W    = 32,
    parameter int LANE_W    = DATA_W / 4,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADR  = 0,
    parameter int NUM_WORDS = 43
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    result_reader_if.master bus,
    output logic            busy,
    output logic            done,
    output logic [2:0]      dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        SEND = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADR);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic [DATA_W-1:0] word_reg;
    logic              accept;
    logic              last_word;

    assign accept    = (state == SEND) && bus.out_ready;
    assign last_word = (word_idx == LAST_IDX);

`ifdef RESULT_READER_PREFETCH_EN
    logic [DATA_W-1:0] pf_reg;
    logic              pf_full;
    logic              pf_pending;
    logic              pf_issue;

    // The only path from out_ready to the read strobe: issue the next word on lane-2 accept.
    assign pf_issue = accept && (lane == 2'd2) && (word_idx < LAST_IDX);
`endif

    always_comb begin
        bus.mem_rd_en  = (state == RD);
        bus.mem_rd_adr = (state == RD) ? BASE + word_idx : '0;
`ifdef RESULT_READER_PREFETCH_EN
        if (pf_issue) begin
            bus.mem_rd_en  = 1'b1;
            bus.mem_rd_adr = BASE + word_idx + ONE;
        end
`endif
        bus.out_valid = (state == SEND);
        bus.out_data  = (state == SEND) ? word_reg[lane*LANE_W +: LANE_W] : '0;
        bus.out_last  = (state == SEND) && (lane == 2'd3) && last_word;
        busy          = (state != IDLE);
        done          = (state == DONE);
        dbg_state     = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            word_idx <= '0;
            lane     <= '0;
            word_reg <= '0;
`ifdef RESULT_READER_PREFETCH_EN
            pf_reg     <= '0;
            pf_full    <= 1'b0;
            pf_pending <= 1'b0;
`endif
        end else begin
`ifdef RESULT_READER_PREFETCH_EN
            pf_pending <= pf_issue;
            if (pf_pending) begin
                pf_reg  <= bus.mem_rd_data;
                pf_full <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RD;
                        word_idx <= '0;
                        lane     <= '0;
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    word_reg <= bus.mem_rd_data;
                    state    <= SEND;
                end
                SEND: begin
                    if (accept) begin
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            if (last_word) begin
                                state <= DONE;
                            end else begin
                                word_idx <= word_idx + ONE;
                                lane     <= 2'd0;
`ifdef RESULT_READER_PREFETCH_EN
                                // Accept in the return cycle itself takes the data straight off the bus.
                                word_reg <= pf_full ? pf_reg : bus.mem_rd_data;
                                pf_full  <= 1'b0;
`else
                                state <= RD;
`endif
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: directed runs with stalls, ignored starts, mid-run reset
// and a single-word run at the top of the address space (second instance).
module tb_result_reader;
    localparam int DATA_W    = 32;
    localparam int LANE_W    = 8;
    localparam int ADDR_W    = 8;
    localparam int NUM_WORDS = 43;
    localparam int BEATS     = NUM_WORDS * 4;
`ifdef RESULT_READER_PREFETCH_EN
    localparam int RUN_CYCLES = 4 * NUM_WORDS + 4;
`else
    localparam int RUN_CYCLES = 6 * NUM_WORDS + 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic       busy, done, busy2, done2;
    logic [2:0] st, st2;

    result_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    result_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus2 ();

    result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADR(0), .NUM_WORDS(NUM_WORDS)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.master),
        .busy(busy), .done(done), .dbg_state(st)
    );

    result_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADR(255), .NUM_WORDS(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bus(bus2.master),
        .busy(busy2), .done(done2), .dbg_state(st2)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- memory models (one-cycle read latency) ----------------
    logic [DATA_W-1:0] mem [256];
    int                rd_cnt = 0;
    int                rd2_cnt = 0;
    logic [ADDR_W-1:0] rd2_adr = '0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            if (i < NUM_WORDS)
                mem[i] = {8'(i*4+3), 8'(i*4+2), 8'(i*4+1), 8'(i*4)};
            else
                mem[i] = 32'hEEEE_EEEE;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_rd_en) begin
            bus.mem_rd_data <= mem[bus.mem_rd_adr];
            rd_cnt          <= rd_cnt + 1;
        end
    end

    always @(posedge clk) begin
        if (bus2.mem_rd_en) begin
            bus2.mem_rd_data <= (bus2.mem_rd_adr == 8'd255) ? 32'hA1B2_C3D4 : 32'hDEAD_BEEF;
            rd2_cnt          <= rd2_cnt + 1;
            rd2_adr          <= bus2.mem_rd_adr;
        end
    end

    // ---------------- scoreboard bookkeeping ----------------
    logic [LANE_W:0] exp_q [$];
    logic [LANE_W:0] exp2_q [$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- out_ready driver ----------------
    int rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: stall lane 3 for 5 cycles
    int beat_cnt = 0;
    int stall_beat = -1;
    int stall_n = 0;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = 1'($urandom_range(0, 1));
            default: begin
                if (beat_cnt != stall_beat) begin
                    stall_beat = beat_cnt;
                    stall_n    = 0;
                end
                if ((beat_cnt % 4 == 3) && (stall_n < 5)) begin
                    bus.out_ready = 1'b0;
                    stall_n++;
                end else begin
                    bus.out_ready = 1'b1;
                end
            end
        endcase
    end

    // ---------------- monitor: main instance ----------------
    logic            held_v = 1'b0;
    logic [LANE_W:0] held;
    logic [LANE_W:0] got;
    int              last_acc_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v)
                check("hold_stable", {bus.out_valid, bus.out_last, bus.out_data}, {1'b1, held});
            got = {bus.out_last, bus.out_data};
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("extra_beat", got, '1);
                else check("beat", got, exp_q.pop_front());
                beat_cnt++;
                last_acc_cyc = cyc;
                held_v = 1'b0;
            end else if (bus.out_valid) begin
                held_v = 1'b1;
                held   = got;
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // ---------------- monitor: single-word instance ----------------
    int beat2_cnt = 0;
    always @(negedge clk) begin
        if (rst && bus2.out_valid && bus2.out_ready) begin
            if (exp2_q.size() == 0) check("top_extra_beat", {bus2.out_last, bus2.out_data}, '1);
            else check("top_beat", {bus2.out_last, bus2.out_data}, exp2_q.pop_front());
            beat2_cnt++;
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic launch(output int t0);
        @(posedge clk);
        #1;
        for (int k = 0; k < BEATS; k++)
            exp_q.push_back({(k == BEATS - 1), 8'(k)});
        start = 1'b1;
        t0    = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int dcyc);
        dcyc = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic check_run_end(input string tag, input int b0, input int rd0);
        check({tag, "_beats"}, beat_cnt - b0, BEATS);
        check({tag, "_reads"}, rd_cnt - rd0, NUM_WORDS);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int  t0, d, rd0, b0;
        bit  seen;
        rst            = 1'b0;
        start          = 1'b0;
        start2         = 1'b0;
        bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {bus.mem_rd_en, bus.mem_rd_adr, bus.out_valid, bus.out_data, bus.out_last, busy, done},
              '0);
        rst = 1'b1;

        // Basic run, always ready; durations count start cycle through done cycle inclusive.
        rdy_mode = 0;
        rd0 = rd_cnt;
        b0  = beat_cnt;
        launch(t0);
        d = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                d = cyc;
                break;
            end
        end
        check("first_valid_latency", d - t0, 3);
        wait_done(d);
        check("run_cycles", d - t0 + 1, RUN_CYCLES);
        check("done_after_last", d - last_acc_cyc, 1);
        check_run_end("basic", b0, rd0);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        // Random backpressure.
        rdy_mode = 1;
        rd0 = rd_cnt;
        b0  = beat_cnt;
        launch(t0);
        wait_done(d);
        check("bp_done_after_last", d - last_acc_cyc, 1);
        check_run_end("bp", b0, rd0);

        // Lane-3 stalls of 5 cycles.
        rdy_mode = 2;
        rd0 = rd_cnt;
        b0  = beat_cnt;
        launch(t0);
        wait_done(d);
        check_run_end("stall3", b0, rd0);

        // Start pulses mid-run and in the DONE cycle must be ignored.
        rdy_mode = 0;
        rd0 = rd_cnt;
        b0  = beat_cnt;
        launch(t0);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (beat_cnt - b0 >= 50) break;
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(d);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("ignored_start_no_restart", seen, 0);
        check_run_end("ignored_start", b0, rd0);

        // Reset during WAIT of word 10 (read of address 10 just issued).
        rd0 = rd_cnt;
        launch(t0);
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rd_cnt - rd0 == 11) begin
                seen = 1'b1;
                break;
            end
        end
        check("reached_word10", seen, 1);
`ifndef RESULT_READER_PREFETCH_EN
        check("in_wait_word10", st, 3'd2);
`endif
        rst = 1'b0;
        #1;
        check("async_reset_outputs",
              {bus.mem_rd_en, bus.mem_rd_adr, bus.out_valid, bus.out_data, bus.out_last, busy, done},
              '0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        rd0 = rd_cnt;
        b0  = beat_cnt;
        launch(t0);
        wait_done(d);
        check("post_reset_run_cycles", d - t0 + 1, RUN_CYCLES);
        check_run_end("post_reset", b0, rd0);

        // Single word at address 255.
        @(posedge clk);
        #1;
        exp2_q.push_back({1'b0, 8'hD4});
        exp2_q.push_back({1'b0, 8'hC3});
        exp2_q.push_back({1'b0, 8'hB2});
        exp2_q.push_back({1'b1, 8'hA1});
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done2) begin
                seen = 1'b1;
                break;
            end
        end
        check("top_done", seen, 1);
        check("top_reads", rd2_cnt, 1);
        check("top_read_adr", rd2_adr, 8'd255);
        check("top_beats", beat2_cnt, 4);
        check("top_queue_empty", exp2_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
